// File: rtl/game_pkg.sv
// Shared maze-game definitions: map geometry, move directions and the
// movement sequencer's state encoding.
package game_pkg;

  localparam int MAP_ROWS  = 21;
  localparam int MAP_COLS  = 30;
  localparam int TILE_SIZE = 20;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    READ   = 2'd2,
    COMMIT = 2'd3
  } move_state_e;

endpackage

// File: rtl/frame_divider.sv
// Divides the per-frame tick down to one move opportunity every MOVE_DIV
// frames. The opportunity is a registered one-cycle pulse that follows the
// wrapping frame tick.
module frame_divider #(
  parameter int MOVE_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  output logic move_opportunity
);

  localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] frame_cnt;

  // Count frame ticks modulo MOVE_DIV; the wrapping tick raises the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt        <= '0;
      move_opportunity <= 1'b0;
    end else begin
      move_opportunity <= 1'b0;
      if (frame_tick) begin
        if (frame_cnt == CNT_LAST) begin
          frame_cnt        <= '0;
          move_opportunity <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/player_move_ctrl.sv
// Player movement sequencer: on each move opportunity picks one direction
// from the buttons, rejects moves off the map immediately, otherwise reads
// the target map row through the shared ROM port and commits the move only
// when the target cell holds no wall.
module player_move_ctrl
  import game_pkg::*;
#(
  parameter int START_X  = 1,
  parameter int START_Y  = 1,
  parameter int MOVE_DIV = 4,
  parameter int READ_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_left,
  input  logic                btn_right,
  output logic                map_req,
  output logic [4:0]          map_addr,
  input  logic                map_grant,
  input  logic [MAP_COLS-1:0] map_data,
  output logic [7:0]          player_x_pos,
  output logic [7:0]          player_y_pos,
  output logic                busy,
  output logic                blocked
);

  localparam logic [7:0]        START_X_POS = 8'(START_X);
  localparam logic [7:0]        START_Y_POS = 8'(START_Y);
  localparam logic [7:0]        LAT_LAST    = 8'(READ_LAT - 1);
  localparam logic [7:0]        COLS_LIMIT  = 8'(MAP_COLS);
  localparam logic signed [8:0] X_MAX       = 9'(MAP_ROWS - 1);
  localparam logic signed [8:0] Y_MAX       = 9'(MAP_COLS - 1);

  move_state_e       state, state_next;
  logic              move_opportunity;
  logic              any_btn;
  dir_e              dir;
  logic signed [8:0] cand_x, cand_y;
  logic              cand_ok;
  logic [31:0]       row_bits;
  logic              row_bit;

  logic [7:0] tgt_x, tgt_y, tgt_x_next, tgt_y_next;
  logic [7:0] lat_cnt, lat_cnt_next;
  logic [7:0] pos_x_next, pos_y_next;
  logic [4:0] map_addr_next;
  logic       map_req_next;
  logic       blocked_next;
  logic       wall, wall_next;

  frame_divider #(
    .MOVE_DIV(MOVE_DIV)
  ) u_frame_divider (
    .clk              (clk),
    .reset            (reset),
    .frame_tick       (frame_tick),
    .move_opportunity (move_opportunity)
  );

  assign busy = (state != IDLE);

  // Pick one direction (up > down > left > right) and form the candidate
  // target in signed 9-bit arithmetic so a step below zero is visible.
  always_comb begin
    any_btn = btn_up | btn_down | btn_left | btn_right;
    dir     = DIR_RIGHT;
    if (btn_up)        dir = DIR_UP;
    else if (btn_down) dir = DIR_DOWN;
    else if (btn_left) dir = DIR_LEFT;
    cand_x = $signed({1'b0, player_x_pos});
    cand_y = $signed({1'b0, player_y_pos});
    case (dir)
      DIR_UP:    cand_y = cand_y - 9'sd1;
      DIR_DOWN:  cand_y = cand_y + 9'sd1;
      DIR_LEFT:  cand_x = cand_x - 9'sd1;
      DIR_RIGHT: cand_x = cand_x + 9'sd1;
    endcase
    cand_ok = (cand_x >= 9'sd0) && (cand_x <= X_MAX) &&
              (cand_y >= 9'sd0) && (cand_y <= Y_MAX);
  end

  // Select the target cell's wall bit; anything past the map width reads as wall.
  always_comb begin
    row_bits = {{(32 - MAP_COLS){1'b1}}, map_data};
    row_bit  = (tgt_y < COLS_LIMIT) ? row_bits[tgt_y[4:0]] : 1'b1;
  end

  // Next-state and registered-output logic for the move sequence.
  always_comb begin
    state_next    = state;
    tgt_x_next    = tgt_x;
    tgt_y_next    = tgt_y;
    lat_cnt_next  = lat_cnt;
    wall_next     = wall;
    map_req_next  = map_req;
    map_addr_next = map_addr;
    blocked_next  = 1'b0;
    pos_x_next    = player_x_pos;
    pos_y_next    = player_y_pos;
    case (state)
      IDLE: begin
        if (move_opportunity && any_btn) begin
          if (!cand_ok) begin
            blocked_next = 1'b1;
          end else begin
            tgt_x_next    = cand_x[7:0];
            tgt_y_next    = cand_y[7:0];
            map_addr_next = cand_x[4:0];
            map_req_next  = 1'b1;
            state_next    = REQ;
          end
        end
      end
      REQ: begin
        if (map_grant) begin
          if (READ_LAT <= 1) begin
            wall_next    = row_bit;
            map_req_next = 1'b0;
            state_next   = COMMIT;
          end else begin
            lat_cnt_next = 8'd1;
            state_next   = READ;
          end
        end
      end
      READ: begin
        if (!map_grant) begin
          lat_cnt_next = 8'd0;
          state_next   = REQ;
        end else if (lat_cnt >= LAT_LAST) begin
          wall_next    = row_bit;
          map_req_next = 1'b0;
          state_next   = COMMIT;
        end else begin
          lat_cnt_next = lat_cnt + 8'd1;
        end
      end
      COMMIT: begin
        if (wall) begin
          blocked_next = 1'b1;
        end else begin
          pos_x_next = tgt_x;
          pos_y_next = tgt_y;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight ROM read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tgt_x        <= 8'd0;
      tgt_y        <= 8'd0;
      lat_cnt      <= 8'd0;
      wall         <= 1'b0;
      map_req      <= 1'b0;
      map_addr     <= 5'd0;
      blocked      <= 1'b0;
      player_x_pos <= START_X_POS;
      player_y_pos <= START_Y_POS;
    end else begin
      state        <= state_next;
      tgt_x        <= tgt_x_next;
      tgt_y        <= tgt_y_next;
      lat_cnt      <= lat_cnt_next;
      wall         <= wall_next;
      map_req      <= map_req_next;
      map_addr     <= map_addr_next;
      blocked      <= blocked_next;
      player_x_pos <= pos_x_next;
      player_y_pos <= pos_y_next;
    end
  end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Scoreboard bench for player_move_ctrl: a maze model plus ROM/arbiter model
// drive the DUT, a reference model predicts every ROM access, blocked pulse
// and position change, and a monitor compares them as they appear.
module tb_player_move_ctrl;

  localparam int MAP_ROWS = 21;
  localparam int MAP_COLS = 30;
  localparam int START_X  = 1;
  localparam int START_Y  = 1;
  localparam int MOVE_DIV = 4;
  localparam int READ_LAT = 2;

  localparam int EV_ACCESS = 0;
  localparam int EV_BLOCK  = 1;
  localparam int EV_MOVE   = 2;

  localparam logic [3:0] B_UP    = 4'b1000;
  localparam logic [3:0] B_DOWN  = 4'b0100;
  localparam logic [3:0] B_LEFT  = 4'b0010;
  localparam logic [3:0] B_RIGHT = 4'b0001;

  typedef struct {
    int kind;
    int x;
    int y;
    int addr;
    int cyc;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                frame_tick;
  logic                btn_up, btn_down, btn_left, btn_right;
  logic                map_req;
  logic [4:0]          map_addr;
  logic                map_grant = 1'b0;
  logic [MAP_COLS-1:0] map_data = '0;
  logic [7:0]          player_x_pos, player_y_pos;
  logic                busy, blocked;

  bit [MAP_COLS-1:0] maze [MAP_ROWS];
  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   mx, my;
  int   tick_count;
  int   grant_delay = 0;
  bit   glitch_en   = 0;
  int   wait_cnt    = 0;
  int   gcount      = 0;
  bit   glitch_done = 0;
  bit [MAP_COLS-1:0] row;

  player_move_ctrl #(
    .START_X  (START_X),
    .START_Y  (START_Y),
    .MOVE_DIV (MOVE_DIV),
    .READ_LAT (READ_LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .map_req      (map_req),
    .map_addr     (map_addr),
    .map_grant    (map_grant),
    .map_data     (map_data),
    .player_x_pos (player_x_pos),
    .player_y_pos (player_y_pos),
    .busy         (busy),
    .blocked      (blocked)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One frame tick pulse; reports the edge that sampled it and whether it
  // was a move opportunity by the bench's own frame count.
  task automatic tick_once(output int edge_no, output bit opp);
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    edge_no = cyc;
    tick_count++;
    opp = ((tick_count % MOVE_DIV) == 0);
  endtask

  task automatic push_exp(input int kind, input int x, input int y, input int addr, input int c);
    exp_t e;
    e.kind = kind;
    e.x    = x;
    e.y    = y;
    e.addr = addr;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Reference model of one move opportunity taken while idle.
  task automatic model_move(input logic [3:0] btns, input int edge_no, input bit exact, input bit abort);
    int tx, ty, lat;
    if (btns == 4'b0000) return;
    tx = mx;
    ty = my;
    if (btns[3])      ty = my - 1;
    else if (btns[2]) ty = my + 1;
    else if (btns[1]) tx = mx - 1;
    else              tx = mx + 1;
    lat = exact ? edge_no + READ_LAT + 2 : -1;
    if (tx < 0 || tx >= MAP_ROWS || ty < 0 || ty >= MAP_COLS) begin
      push_exp(EV_BLOCK, mx, my, 0, edge_no + 1);
    end else begin
      push_exp(EV_ACCESS, 0, 0, tx, edge_no + 1);
      if (!abort) begin
        if (maze[tx][ty]) begin
          push_exp(EV_BLOCK, mx, my, 0, lat);
        end else begin
          mx = tx;
          my = ty;
          push_exp(EV_MOVE, tx, ty, 0, lat);
        end
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      wait_cycles(1);
      n++;
    end
    check_output("drain", exp_q.size(), 0);
    exp_q.delete();
    wait_cycles(2);
  endtask

  task automatic set_buttons(input logic [3:0] btns);
    {btn_up, btn_down, btn_left, btn_right} = btns;
  endtask

  // Ticks until an opportunity, predicts its outcome and waits for it.
  task automatic apply_stimulus(input logic [3:0] btns, input int delay, input bit glitch);
    int edge_no;
    bit opp;
    set_buttons(btns);
    grant_delay = delay;
    glitch_en   = glitch;
    opp = 0;
    while (!opp) begin
      wait_cycles($urandom_range(0, 2));
      tick_once(edge_no, opp);
    end
    model_move(btns, edge_no, (delay == 0) && !glitch, 1'b0);
    drain();
    set_buttons(4'b0000);
  endtask

  task automatic open_maze();
    for (int r = 0; r < MAP_ROWS; r++) maze[r] = '0;
  endtask

  // ROM/arbiter model: grants after grant_delay cycles of request, can drop
  // the grant once, and presents the true row only in the cycle before the
  // READ_LAT-th granted edge (inverted data otherwise).
  initial forever begin
    @(negedge clk);
    gcount = (map_grant === 1'b1) ? gcount + 1 : 0;
    if (map_req !== 1'b1) begin
      map_grant   = 1'b0;
      wait_cnt    = 0;
      glitch_done = 0;
      gcount      = 0;
    end else if (!map_grant) begin
      if (wait_cnt >= grant_delay) map_grant = 1'b1;
      else wait_cnt++;
    end else if (glitch_en && !glitch_done) begin
      map_grant   = 1'b0;
      glitch_done = 1;
    end
    row = (int'(map_addr) < MAP_ROWS) ? maze[map_addr] : '1;
    map_data = (gcount == READ_LAT - 1) ? row : ~row;
  end

  task automatic score(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL unexpected_event: got kind %0d at (%0d,%0d) cycle %0d, required none",
               kind, player_x_pos, player_y_pos, cyc);
    end else begin
      e = exp_q.pop_front();
      check_output("event_kind", kind, e.kind);
      if (kind == EV_ACCESS) begin
        check_output("access_addr", map_addr, e.addr);
        check_output("access_busy", busy, 1);
      end else begin
        check_output("event_x", player_x_pos, e.x);
        check_output("event_y", player_y_pos, e.y);
      end
      if (e.cyc >= 0) check_output("event_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: ROM request rises, blocked pulses and position changes.
  initial begin
    logic       prev_req;
    logic [7:0] prev_x, prev_y;
    prev_req = 1'b0;
    prev_x   = 8'd0;
    prev_y   = 8'd0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        if (map_req && !prev_req) score(EV_ACCESS);
        if (blocked) score(EV_BLOCK);
        if (player_x_pos != prev_x || player_y_pos != prev_y) score(EV_MOVE);
      end
      prev_req = map_req;
      prev_x   = player_x_pos;
      prev_y   = player_y_pos;
    end
  end

  initial begin
    int  edge_no;
    bit  opp;
    int  exp_addr;
    reset      = 1'b1;
    frame_tick = 1'b0;
    set_buttons(4'b0000);
    open_maze();
    tick_count = 0;
    mx = START_X;
    my = START_Y;

    wait_cycles(3);
    @(negedge clk);
    check_output("reset_x", player_x_pos, START_X);
    check_output("reset_y", player_y_pos, START_Y);
    check_output("reset_req", map_req, 0);
    check_output("reset_addr", map_addr, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_blocked", blocked, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] wall above start blocks an up move");
    maze[1][0] = 1'b1;
    apply_stimulus(B_UP, 0, 0);

    $display("[TB] up+right with open cells moves only in y");
    maze[1][0] = 1'b0;
    apply_stimulus(B_UP | B_RIGHT, 0, 0);
    apply_stimulus(B_DOWN, 0, 0);

    $display("[TB] right move with immediate grant");
    apply_stimulus(B_RIGHT, 0, 0);

    $display("[TB] walk to (0,5) and push against x=0");
    apply_stimulus(B_LEFT, 0, 0);
    apply_stimulus(B_LEFT, 0, 0);
    for (int i = 0; i < 4; i++) apply_stimulus(B_DOWN, 0, 0);
    apply_stimulus(B_LEFT, 0, 0);

    $display("[TB] long grant wait drops opportunities");
    set_buttons(B_RIGHT);
    grant_delay = 500;
    glitch_en   = 0;
    exp_addr    = mx + 1;
    opp = 0;
    while (!opp) tick_once(edge_no, opp);
    model_move(B_RIGHT, edge_no, 1'b0, 1'b0);
    wait_cycles(1);
    for (int i = 0; i < 12; i++) begin
      wait_cycles(8);
      check_output("wait_busy", busy, 1);
      check_output("wait_req", map_req, 1);
      check_output("wait_addr", map_addr, exp_addr);
      tick_once(edge_no, opp);
    end
    drain();
    set_buttons(4'b0000);

    $display("[TB] reset while reading");
    set_buttons((my < MAP_COLS - 1) ? B_DOWN : B_UP);
    grant_delay = 0;
    opp = 0;
    while (!opp) tick_once(edge_no, opp);
    model_move((my < MAP_COLS - 1) ? B_DOWN : B_UP, edge_no, 1'b1, 1'b1);
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(1);
    @(negedge clk);
    check_output("rst_read_x", player_x_pos, START_X);
    check_output("rst_read_y", player_y_pos, START_Y);
    check_output("rst_read_req", map_req, 0);
    check_output("rst_read_busy", busy, 0);
    check_output("rst_read_blocked", blocked, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_buttons(4'b0000);
    mx = START_X;
    my = START_Y;
    tick_count = 0;
    drain();

    $display("[TB] randomized moves");
    for (int t = 0; t < 120; t++) begin
      if (t % 20 == 0) begin
        for (int r = 0; r < MAP_ROWS; r++)
          for (int c = 0; c < MAP_COLS; c++)
            maze[r][c] = ($urandom_range(0, 3) == 0);
      end
      apply_stimulus(4'($urandom_range(0, 15)),
                     ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 20)),
                     ($urandom_range(0, 4) == 0));
    end

    $display("[TB] walk to (20,29) and push against the far edges");
    open_maze();
    while (mx < MAP_ROWS - 1) apply_stimulus(B_RIGHT, 0, 0);
    while (my < MAP_COLS - 1) apply_stimulus(B_DOWN, 0, 0);
    apply_stimulus(B_RIGHT, 0, 0);
    apply_stimulus(B_DOWN, 0, 0);
    check_output("final_x", player_x_pos, MAP_ROWS - 1);
    check_output("final_y", player_y_pos, MAP_COLS - 1);

    wait_cycles(5);
    check_output("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
